// File: rtl/instr_mem_pipe.sv
// Instruction memory with a valid/ready request and response channel, byte-enable writes,
// LATENCY-deep response pipeline, and alignment/range error reporting.
module instr_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NB-1:0][7:0] mem [DEPTH];

  logic                stall, accept, err_in;
  logic [ADDR_W-3:0]   word;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   rd_in;

  logic [LATENCY:1]    vld_pipe;
  logic [LATENCY:1]    err_pipe;
  logic [DATA_W-1:0]   dat_pipe [1:LATENCY];

  // Only the output stage can stall; the whole pipe freezes with it, bubbles included.
  assign stall     = vld_pipe[LATENCY] && !rsp_ready;
  assign req_ready = rst_n && !stall;
  assign accept    = req_valid && req_ready;

  assign word   = req_addr[ADDR_W-1:2];
  assign idx    = word[IDX_W-1:0];
  assign err_in = (req_addr[1:0] != 2'b00) || (32'(word) >= 32'(DEPTH));
  assign rd_in  = (err_in || req_we) ? '0 : mem[idx];

  // Memory is not reset; writes commit on the accept edge, erroring writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_in) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[idx][b] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) dat_pipe[i] <= '0;
    end else if (!stall) begin
      vld_pipe[1] <= accept;
      err_pipe[1] <= accept && err_in;
      dat_pipe[1] <= accept ? rd_in : '0;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rsp_valid = vld_pipe[LATENCY];
  assign rsp_err   = err_pipe[LATENCY];
  assign rsp_rdata = dat_pipe[LATENCY];

endmodule
